// File: rtl/relu_seq_if.sv
// relu_seq_if: streaming data bundle for the masked ReLU sequencer.
//
// Handshake rule, applied to both directions: a beat transfers on a
// rising clock edge where valid && ready are both high. A source that has
// raised valid keeps valid and its data stable until that edge. ready may
// depend combinationally on the sink's own state.
//
// Signals
//   in_valid / in_ready : producer -> sequencer handshake
//   g_input  [2N-1:0]   : garbler shares, r1 in the upper half, r2 in the lower
//   e_input  [N-1:0]    : evaluator share, x - r1 mod 2^N
//   out_valid/out_ready : sequencer -> consumer handshake
//   o        [N-1:0]    : re-masked ReLU result
//
// Modports: master = producer/consumer side, slave = sequencer side.
interface relu_seq_if #(
  parameter int N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] g_input;
  logic [N-1:0]   e_input;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   o;

  modport master (
    output in_valid, g_input, e_input, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, g_input, e_input, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/relu_seq.sv
// relu_seq: vector sequencer for a share-masked ReLU.
//
// For each accepted element the two shares are recombined into
// x = r1 + e (mod 2^N), clipped to zero when negative, and re-masked with
// r2 before being held in a single output register. One element per cycle
// is sustained when the consumer keeps out_ready high.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   start     : one-cycle request to begin a vector (honoured in IDLE only)
//   len       : element count captured with start; 0 completes immediately
//   busy      : high in RUN and DRAIN
//   done      : one-cycle completion pulse (DONE state)
//   clip_cnt  : count of negative x in the current/last vector, saturating
//   dbg_state : current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   bus       : data streams, see relu_seq_if
module relu_seq #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] clip_cnt,
  output logic [1:0]       dbg_state,
  relu_seq_if.slave        bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CLIP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] clip_cnt_q, clip_cnt_d;
  logic [N-1:0]     o_q, o_d;
  logic             out_valid_q, out_valid_d;

  logic [N-1:0] r1, r2, x, y;
  logic         in_ready;
  logic         accept;
  logic         consume;

  always_comb begin
    r1 = bus.g_input[2*N-1:N];
    r2 = bus.g_input[N-1:0];
    // Carry out of the share sum is dropped: arithmetic is mod 2^N.
    x  = r1 + bus.e_input;
    y  = x[N-1] ? '0 : x;

    // The output register can take a new element if it is empty or is
    // being emptied on this same edge.
    in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    consume  = out_valid_q && bus.out_ready;
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clip_cnt_d  = clip_cnt_q;
    o_d         = o_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          clip_cnt_d = '0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_ONE;
          if (x[N-1] && (clip_cnt_q != CLIP_MAX)) begin
            clip_cnt_d = clip_cnt_q + CNT_ONE;
          end
          if (remaining_q == CNT_ONE) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!out_valid_q || bus.out_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A simultaneous accept overrides the consume so the register stays
    // full and streaming continues without a bubble.
    if (accept) begin
      o_d         = y - r2;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      clip_cnt_q  <= '0;
      o_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      clip_cnt_q  <= clip_cnt_d;
      o_q         <= o_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign clip_cnt      = clip_cnt_q;
  assign dbg_state     = state_q;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.o         = o_q;

endmodule

// File: tb/tb_relu_seq.sv
module tb_relu_seq;

  localparam int N     = 8;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] clip_cnt;
  logic [1:0]       dbg_state;

  relu_seq_if #(.N(N)) bus ();

  relu_seq #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .clip_cnt  (clip_cnt),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- directed element table (hand computed) ----------------
  //  idx r1  r2  e   x   neg  o
  //  0   10  05  20  30  no   2B
  //  1   80  03  10  90  yes  FD
  //  2   FF  00  01  00  no   00
  //  3   7F  10  00  7F  no   6F
  //  4   40  FF  40  80  yes  01
  //  5   C0  20  50  10  no   F0
  //  6   01  01  FE  FF  yes  FF
  //  7   33  44  22  55  no   11
  logic [7:0] t_r1 [8] = '{8'h10, 8'h80, 8'hFF, 8'h7F, 8'h40, 8'hC0, 8'h01, 8'h33};
  logic [7:0] t_r2 [8] = '{8'h05, 8'h03, 8'h00, 8'h10, 8'hFF, 8'h20, 8'h01, 8'h44};
  logic [7:0] t_e  [8] = '{8'h20, 8'h10, 8'h01, 8'h00, 8'h40, 8'h50, 8'hFE, 8'h22};
  logic [7:0] t_o  [8] = '{8'h2B, 8'hFD, 8'h00, 8'h6F, 8'h01, 8'hF0, 8'hFF, 8'h11};

  // ---------------- scoreboard ----------------
  logic [N-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  int cyc = 0;
  int acc_cnt, out_cnt, done_cnt;
  int first_acc, last_acc, first_out, last_out;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_cnt++;
        if (acc_cnt == 1) first_acc = cyc;
        last_acc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (out_cnt == 1) first_out = cyc;
        last_out = cyc;
        if (exp_q.size() > 0) check_val("out_o", 32'(bus.o), 32'(exp_q.pop_front()));
        else                  check_val("out_queue_size", 32'(exp_q.size()), 1);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_counters();
    acc_cnt = 0; out_cnt = 0; done_cnt = 0;
    first_acc = 0; last_acc = 0; first_out = 0; last_out = 0;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
  endtask

  task automatic feed(input int base, input int cnt);
    int   idx;
    logic acc;
    for (int i = 0; i < cnt; i++) begin
      idx = (base + i) % 8;
      bus.in_valid = 1'b1;
      bus.g_input  = {t_r1[idx], t_r2[idx]};
      bus.e_input  = t_e[idx];
      acc = 1'b0;
      for (int k = 0; k < 60 && !acc; k++) begin
        @(negedge clk);
        acc = bus.in_ready;
        if (acc) exp_q.push_back(t_o[idx]);
        @(posedge clk); #1;
      end
      check_val("in_accept", 32'(acc), 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
    end
    check_val("done_seen", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic stall_first();
    for (int k = 0; k < 60 && !bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_val("stall_in_ready", 32'(bus.in_ready), 0);
      check_val("stall_out_valid", 32'(bus.out_valid), 1);
      check_val("stall_o", 32'(bus.o), 32'h FF);
    end
    bus.out_ready = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0; len = '0;
    bus.in_valid = 1'b0; bus.g_input = '0; bus.e_input = '0; bus.out_ready = 1'b1;
    clr_counters();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_state", 32'(dbg_state), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_in_ready", 32'(bus.in_ready), 0);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    check_val("rst_o", 32'(bus.o), 0);
    check_val("rst_clip", 32'(clip_cnt), 0);
    rst = 1'b1;

    // single positive element: o one cycle after accept, done after consume
    clr_counters();
    do_start(1);
    check_val("t1_busy", 32'(busy), 1);
    feed(0, 1);
    check_val("t1_out_valid", 32'(bus.out_valid), 1);
    check_val("t1_o", 32'(bus.o), 32'h2B);
    @(posedge clk); #1;
    check_val("t1_done", 32'(done), 1);
    check_val("t1_clip", 32'(clip_cnt), 0);
    @(posedge clk); #1;
    check_val("t1_done_clear", 32'(done), 0);
    check_val("t1_done_cnt", 32'(done_cnt), 1);

    // single negative element
    clr_counters();
    do_start(1);
    feed(1, 1);
    check_val("t2_o", 32'(bus.o), 32'hFD);
    wait_done();
    check_val("t2_clip", 32'(clip_cnt), 1);

    // len=4 full throughput
    clr_counters();
    do_start(4);
    feed(2, 4);
    wait_done();
    check_val("t3_acc_cnt", 32'(acc_cnt), 4);
    check_val("t3_acc_span", 32'(last_acc - first_acc), 3);
    check_val("t3_out_cnt", 32'(out_cnt), 4);
    check_val("t3_out_span", 32'(last_out - first_out), 3);
    check_val("t3_done_cnt", 32'(done_cnt), 1);
    check_val("t3_clip", 32'(clip_cnt), 1);
    check_val("t3_queue", 32'(exp_q.size()), 0);

    // len=3 with 5-cycle consumer stall after first result
    clr_counters();
    do_start(3);
    fork
      feed(6, 3);
      stall_first();
    join
    wait_done();
    check_val("t4_out_cnt", 32'(out_cnt), 3);
    check_val("t4_clip", 32'(clip_cnt), 1);
    check_val("t4_queue", 32'(exp_q.size()), 0);

    // len=0 completes at once; clip_cnt cleared
    clr_counters();
    do_start(0);
    check_val("t5_done", 32'(done), 1);
    check_val("t5_in_ready", 32'(bus.in_ready), 0);
    check_val("t5_clip", 32'(clip_cnt), 0);
    @(posedge clk); #1;
    check_val("t5_acc_cnt", 32'(acc_cnt), 0);
    check_val("t5_done_cnt", 32'(done_cnt), 1);

    // second start during RUN is ignored
    clr_counters();
    do_start(2);
    do_start(5);
    check_val("t6_state_run", 32'(dbg_state), 1);
    feed(3, 2);
    wait_done();
    check_val("t6_acc_cnt", 32'(acc_cnt), 2);
    check_val("t6_done_cnt", 32'(done_cnt), 1);
    check_val("t6_clip", 32'(clip_cnt), 1);

    // reset mid-vector with a pending output
    clr_counters();
    bus.out_ready = 1'b0;
    do_start(3);
    feed(5, 1);
    check_val("t7_pre_out_valid", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t7_rst_out_valid", 32'(bus.out_valid), 0);
    check_val("t7_rst_o", 32'(bus.o), 0);
    check_val("t7_rst_busy", 32'(busy), 0);
    check_val("t7_rst_in_ready", 32'(bus.in_ready), 0);
    check_val("t7_rst_state", 32'(dbg_state), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.out_ready = 1'b1;
    clr_counters();
    do_start(2);
    check_val("t7_restart_state", 32'(dbg_state), 1);
    feed(0, 2);
    wait_done();
    check_val("t7_out_cnt", 32'(out_cnt), 2);
    check_val("t7_done_cnt", 32'(done_cnt), 1);
    check_val("t7_clip", 32'(clip_cnt), 1);
    check_val("t7_queue", 32'(exp_q.size()), 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
